rf_dump_streamer: RTL and testbench

//   Hardware-side counterpart to the bench's end-of-run register-file check. On a start

---
 rtl/rf_dump_streamer.sv | 158 +++++++++++++++
 tb/tb_rf_dump_streamer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_streamer.sv
// rf_dump_streamer: walks the register file on a start pulse and streams
// each {index, value} pair on a valid/ready port with a running checksum.
//
// Ports:
//   clk, reset (async, active-low)  clock and reset
//   start                           dump request, sampled only in IDLE
//   busy, done                      dump in progress / one-cycle completion pulse
//   rf_raddr, rf_rdata              combinational register-file read port
//   out_valid, out_ready            output stream handshake
//   out_idx, out_data               current beat: register index and value
//   checksum                        sum mod 2^XLEN of every value pushed in this dump
`timescale 1ns/1ps
module rf_dump_streamer #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] rf_raddr,
   input  logic [XLEN-1:0]  rf_rdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [XLEN-1:0]  out_data,
   output logic [XLEN-1:0]  checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_e;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NREGS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [XLEN-1:0]  sum_q, sum_d;

   // Two-entry FIFO: the head entry drives the stream outputs directly,
   // the second entry catches a push while the head is stalled.
   logic             hv_q, hv_d;
   logic [IDX_W-1:0] hidx_q, hidx_d;
   logic [XLEN-1:0]  hdat_q, hdat_d;
   logic             sv_q, sv_d;
   logic [IDX_W-1:0] sidx_q, sidx_d;
   logic [XLEN-1:0]  sdat_q, sdat_d;

   logic             busy_q, done_q;
   logic             pop, push, last;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sum_d   = sum_q;
      hv_d    = hv_q;
      hidx_d  = hidx_q;
      hdat_d  = hdat_q;
      sv_d    = sv_q;
      sidx_d  = sidx_q;
      sdat_d  = sdat_q;

      pop  = hv_q && out_ready;
      push = (state_q == S_RUN) && (!(hv_q && sv_q) || pop);
      last = push && (ptr_q == LAST);

      if (push) begin
         ptr_d = ptr_q + 1'b1;
         sum_d = sum_q + rf_rdata;
      end

      if (!hv_q || pop) begin
         if (sv_q) begin
            hv_d   = 1'b1;
            hidx_d = sidx_q;
            hdat_d = sdat_q;
            sv_d   = push;
            if (push) begin
               sidx_d = ptr_q;
               sdat_d = rf_rdata;
            end
         end else if (push) begin
            hv_d   = 1'b1;
            hidx_d = ptr_q;
            hdat_d = rf_rdata;
         end else begin
            hv_d = 1'b0;
         end
      end else if (push) begin
         sv_d   = 1'b1;
         sidx_d = ptr_q;
         sdat_d = rf_rdata;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               ptr_d   = '0;
               sum_d   = '0;
            end
         end
         S_RUN: begin
            if (last) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            // Leave as soon as the final pop empties the FIFO.
            if (!hv_d && !sv_d) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sum_q   <= '0;
         hv_q    <= 1'b0;
         hidx_q  <= '0;
         hdat_q  <= '0;
         sv_q    <= 1'b0;
         sidx_q  <= '0;
         sdat_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sum_q   <= sum_d;
         hv_q    <= hv_d;
         hidx_q  <= hidx_d;
         hdat_q  <= hdat_d;
         sv_q    <= sv_d;
         sidx_q  <= sidx_d;
         sdat_q  <= sdat_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rf_raddr  = (state_q == S_RUN) ? ptr_q : '0;
   assign out_valid = hv_q;
   assign out_idx   = hidx_q;
   assign out_data  = hdat_q;
   assign checksum  = sum_q;

endmodule

// File: tb/tb_rf_dump_streamer.sv
// tb_rf_dump_streamer: directed bench for rf_dump_streamer.
// Models the register file as an array and checks every beat it streams.
`timescale 1ns/1ps
module tb_rf_dump_streamer;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;
   localparam int IDX_W = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             out_ready = 1'b1;
   logic             busy, done, out_valid;
   logic [IDX_W-1:0] rf_raddr, out_idx;
   logic [XLEN-1:0]  rf_rdata, out_data, checksum;

   logic [XLEN-1:0]  rf [NREGS];

   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;
   int               beats = 0;
   int               first_cyc = 0;
   int               last_cyc = 0;
   logic [IDX_W-1:0] exp_idx = '0;
   logic             hold_pend = 1'b0;
   logic [IDX_W-1:0] hidx = '0;
   logic [XLEN-1:0]  hdat = '0;

   rf_dump_streamer #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .IDX_W(IDX_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rf_raddr (rf_raddr),
      .rf_rdata (rf_rdata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_idx  (out_idx),
      .out_data (out_data),
      .checksum (checksum)
   );

   always #5 clk = ~clk;

   assign rf_rdata = rf[rf_raddr];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stream monitor: ordering, data, and stall stability.
   always @(negedge clk) begin
      if (!reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_idx", 64'(out_idx), 64'(hidx));
            chk("hold_data", out_data, hdat);
         end
         hold_pend = out_valid && !out_ready;
         hidx = out_idx;
         hdat = out_data;
         if (out_valid && out_ready) begin
            chk("beat_idx", 64'(out_idx), 64'(exp_idx));
            chk("beat_data", out_data, rf[exp_idx]);
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
            exp_idx = exp_idx + 1'b1;
         end
      end
   end

   // mode 0: ready=1 with latency checks; 1: ready toggles;
   // 2: extra start at beat 5 and at done; 3: reset at beat 10
   task automatic do_dump(input int mode, input logic [63:0] exp_sum);
      int  n0;
      bit  got_done;
      bit  restarted;
      got_done  = 1'b0;
      restarted = 1'b0;
      beats     = 0;
      exp_idx   = '0;
      @(posedge clk); #1;
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n0    = cyc;
      chk("busy_after_start", 64'(busy), 64'd1);
      for (int i = 0; i < 300; i++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (mode == 3 && beats >= 10) begin
            reset = 1'b0;
            #1;
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_sum", checksum, 64'd0);
            chk("rst_raddr", 64'(rf_raddr), 64'd0);
            chk("rst_idx", 64'(out_idx), 64'd0);
            chk("rst_data", out_data, 64'd0);
            repeat (2) @(posedge clk);
            #1;
            chk("rst_hold_valid", 64'(out_valid), 64'd0);
            reset = 1'b1;
            return;
         end
         out_ready = (mode == 1) ? ~out_ready : 1'b1;
         start = (mode == 2 && beats >= 5 && !restarted);
         if (start) restarted = 1'b1;
         @(posedge clk); #1;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      chk("done_seen", 64'(got_done), 64'd1);
      if (!got_done) return;
      chk("busy_with_done", 64'(busy), 64'd1);
      chk("beat_count", 64'(beats), 64'(NREGS));
      chk("checksum", checksum, exp_sum);
      if (mode == 0) begin
         chk("first_beat_lat", 64'(first_cyc - n0), 64'd1);
         chk("last_beat_lat", 64'(last_cyc - n0), 64'(NREGS));
         chk("done_lat", 64'(cyc - n0), 64'(NREGS + 1));
      end
      if (mode == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_drop", 64'(busy), 64'd0);
      chk("done_drop", 64'(done), 64'd0);
      @(posedge clk); #1;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("sum_hold", checksum, exp_sum);
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("last_idx_hold", 64'(out_idx), 64'(NREGS - 1));
      chk("last_data_hold", out_data, rf[NREGS-1]);
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) rf[i] = 64'(3 * i);

      // Reset held, start low.
      repeat (4) begin
         @(negedge clk);
         chk("reset_busy", 64'(busy), 64'd0);
         chk("reset_done", 64'(done), 64'd0);
         chk("reset_valid", 64'(out_valid), 64'd0);
         chk("reset_sum", checksum, 64'd0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", 64'(busy), 64'd0);

      do_dump(0, 64'd1488);
      do_dump(1, 64'd1488);
      do_dump(2, 64'd1488);
      do_dump(3, 64'd1488);
      do_dump(0, 64'd1488);

      for (int i = 1; i < NREGS; i++) rf[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      do_dump(0, 64'hFFFF_FFFF_FFFF_FFE1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
